// File: rtl/float_pack.sv
// Shared opcode constants, controller state type and rounding helpers for the
// single-precision coprocessor.
package float_pack;

   localparam logic [10:0] OP_ADD = 11'd0;
   localparam logic [10:0] OP_SUB = 11'd1;
   localparam logic [10:0] OP_MUL = 11'd2;
   localparam logic [10:0] OP_DIV = 11'd3;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } copro_state_t;

   // Leading-zero count of a 27-bit significand; 27 when all bits are zero.
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) lzc27 = 5'(26 - i);
      end
   endfunction

   // m carries the leading one at bit 26, 23 fraction bits, then guard,
   // round and sticky. Rounds to nearest-even, saturates to inf, flushes to 0.
   function automatic logic [31:0] round_pack(input logic s,
                                              input logic signed [11:0] e,
                                              input logic [26:0] m);
      logic               inc;
      logic [24:0]        r;
      logic signed [11:0] ex;
      logic [4:0]         unused_bits;
      inc = m[2] & (m[1] | m[0] | m[3]);
      r   = {1'b0, m[26:3]} + 25'(inc);
      ex  = e;
      if (r[24]) begin
         r  = r >> 1;
         ex = ex + 12'sd1;
      end
      unused_bits = {r[23], ex[11:8]};
      if (ex >= 12'sd255)
         round_pack = {s, 8'hFF, 23'd0};
      else if (ex <= 12'sd0)
         round_pack = {s, 31'd0};
      else
         round_pack = {s, ex[7:0], r[22:0]};
   endfunction

endpackage

// File: rtl/float_copro_dp.sv
// Combinational single-precision add/sub/mult/div datapath. Denormal inputs
// are treated as zero; the controller gives these paths multiple cycles.
module float_copro_dp
   import float_pack::*;
(
   input  logic [10:0] opc,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);

   logic        sa, sb;
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb;

   assign sa = a[31];
   assign sb = b[31];
   assign ea = a[30:23];
   assign eb = b[30:23];
   assign ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
   assign mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};

   logic               sb_eff, swap, sx, sy, sticky;
   logic [7:0]         ex, ey, d;
   logic [4:0]         sh, lz;
   logic [26:0]        mx, my, my_sh, add_m;
   logic [27:0]        sum;
   logic signed [11:0] add_e;
   logic [31:0]        add_res;

   // Add/sub: order by magnitude so the subtraction never goes negative.
   always_comb begin
      sb_eff = sb ^ (opc == OP_SUB);
      swap   = {ea, ma} < {eb, mb};
      sx     = swap ? sb_eff : sa;
      sy     = swap ? sa : sb_eff;
      ex     = swap ? eb : ea;
      ey     = swap ? ea : eb;
      mx     = {(swap ? mb : ma), 3'b000};
      my     = {(swap ? ma : mb), 3'b000};
      d      = ex - ey;
      sh     = (d > 8'd27) ? 5'd27 : d[4:0];
      my_sh  = my >> sh;
      sticky = |(my & ~(27'h7FFFFFF << sh));
      if (sx ^ sy)
         sum = {1'b0, mx} - {1'b0, my_sh | 27'(sticky)};
      else
         sum = {1'b0, mx} + {1'b0, my_sh | 27'(sticky)};
      lz = lzc27(sum[26:0]);
      if (sum[27]) begin
         add_m = {sum[27:2], sum[1] | sum[0]};
         add_e = $signed({4'd0, ex}) + 12'sd1;
      end else begin
         add_m = sum[26:0] << lz;
         add_e = $signed({4'd0, ex}) - $signed({7'd0, lz});
      end
      add_res = (sum == 28'd0) ? 32'd0 : round_pack(sx, add_e, add_m);
   end

   logic [47:0]        prod;
   logic [26:0]        mul_m;
   logic signed [11:0] mul_e;
   logic [31:0]        mul_res;

   always_comb begin
      prod  = ma * mb;
      mul_e = $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd127;
      if (prod[47]) begin
         mul_m = {prod[47:22], |prod[21:0]};
         mul_e = mul_e + 12'sd1;
      end else begin
         mul_m = {prod[46:21], |prod[20:0]};
      end
      if (ma == 24'd0 || mb == 24'd0)
         mul_res = {sa ^ sb, 31'd0};
      else
         mul_res = round_pack(sa ^ sb, mul_e, mul_m);
   end

   logic [23:0]        dvs, rem;
   logic [49:0]        num;
   logic [26:0]        quo, div_m;
   logic signed [11:0] div_e;
   logic [31:0]        div_res;

   // Quotient of two 1.x significands lands in [2^25, 2^27) after the pre-shift.
   always_comb begin
      dvs   = (mb == 24'd0) ? 24'd1 : mb;
      num   = {ma, 26'd0};
      quo   = 27'(num / {26'd0, dvs});
      rem   = 24'(num % {26'd0, dvs});
      div_e = $signed({4'd0, ea}) - $signed({4'd0, eb}) + 12'sd127;
      if (quo[26]) begin
         div_m = {quo[26:1], quo[0] | (rem != 24'd0)};
      end else begin
         div_m = {quo[25:0], rem != 24'd0};
         div_e = div_e - 12'sd1;
      end
      if (mb == 24'd0)
         div_res = (ma == 24'd0) ? 32'h7FC0_0000 : {sa ^ sb, 8'hFF, 23'd0};
      else if (ma == 24'd0)
         div_res = {sa ^ sb, 31'd0};
      else
         div_res = round_pack(sa ^ sb, div_e, div_m);
   end

   always_comb begin
      case (opc)
         OP_ADD, OP_SUB: result = add_res;
         OP_MUL:         result = mul_res;
         OP_DIV:         result = div_res;
         default:        result = 32'd0;
      endcase
   end

endmodule

// File: rtl/float_copro_ctrl.sv
// Sequencer for float_copro_dp: latches a request, holds the operands for the
// opcode's multicycle latency, then registers the result with a completion pulse.
module float_copro_ctrl
   import float_pack::*;
#(
   parameter int LAT_ADD = 2,
   parameter int LAT_MUL = 3,
   parameter int LAT_DIV = 8
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        valid_i,
   input  logic [10:0] opcode_i,
   input  logic [31:0] op0_i,
   input  logic [31:0] op1_i,
   output logic [31:0] result_o,
   output logic        complete_o,
   output logic        err_o,
   output logic        busy_o
);

   copro_state_t state_q, state_next;
   logic [10:0]  opc_q, opc_next;
   logic [31:0]  a_q, a_next, b_q, b_next;
   logic [31:0]  result_q, result_next;
   logic [7:0]   cnt_q, cnt_next;
   logic         err_q, err_next;
   logic [31:0]  dp_result;
   logic         illegal;

   function automatic logic [7:0] lat_of(input logic [10:0] opc);
      case (opc)
         OP_ADD, OP_SUB: lat_of = 8'(LAT_ADD);
         OP_MUL:         lat_of = 8'(LAT_MUL);
         OP_DIV:         lat_of = 8'(LAT_DIV);
         default:        lat_of = 8'd1;
      endcase
   endfunction

   float_copro_dp u_dp (
      .opc    (opc_q),
      .a      (a_q),
      .b      (b_q),
      .result (dp_result)
   );

   assign illegal = (opc_q > OP_DIV);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         opc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_next;
         opc_q    <= opc_next;
         a_q      <= a_next;
         b_q      <= b_next;
         cnt_q    <= cnt_next;
         result_q <= result_next;
         err_q    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_q;
      opc_next    = opc_q;
      a_next      = a_q;
      b_next      = b_q;
      cnt_next    = cnt_q;
      result_next = result_q;
      err_next    = err_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               opc_next   = opcode_i;
               a_next     = op0_i;
               b_next     = op1_i;
               cnt_next   = lat_of(opcode_i) - 8'd1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != 8'd0) begin
               cnt_next = cnt_q - 8'd1;
            end else begin
               result_next = illegal ? 32'd0 : dp_result;
               err_next    = illegal;
               state_next  = DONE;
            end
         end
         DONE: begin
            err_next   = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign result_o   = result_q;
   assign err_o      = err_q;
   assign complete_o = (state_q == DONE);
   assign busy_o     = (state_q != IDLE);

endmodule
